// File: rtl/zero_pad_stream_if.sv
// Valid/ready beat stream with a frame-end marker.
// The slave side omits last because an input stream carries no frame marker.
interface zero_pad_stream_if #(
    parameter int DW = 1024
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/zero_pad_stream.sv
// Streaming zero-padder: wraps a HEIGHT x WIDTH raster of pixel beats in a p-beat
// border of zeros, with a single output register stage.
module zero_pad_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 32,
    parameter int WIDTH      = 13,
    parameter int HEIGHT     = 17,
    parameter int MAX_PAD    = 2,
    localparam int PW        = $clog2(MAX_PAD + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PW-1:0]            cfg_pad,
    output logic                     busy,
    output logic                     done,
    zero_pad_stream_if.slave         in_s,
    zero_pad_stream_if.master        out_m
);
    localparam int DW = CHANNELS * DATA_WIDTH;
    localparam int RW = $clog2(HEIGHT + 2 * MAX_PAD + 1);
    localparam int CW = $clog2(WIDTH + 2 * MAX_PAD + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pad_q, pad_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;

    logic          in_ready;
    logic          ld;
    logic          advance;
    logic          interior;
    logic          last_beat;
    logic [RW-1:0] row_lim;
    logic [CW-1:0] col_lim;

    // Padded frame extents and the position of the next beat within them.
    assign row_lim   = RW'(HEIGHT) + RW'(pad_q) + RW'(pad_q);
    assign col_lim   = CW'(WIDTH) + CW'(pad_q) + CW'(pad_q);
    assign interior  = (row_q >= RW'(pad_q)) && (row_q < RW'(HEIGHT) + RW'(pad_q)) &&
                       (col_q >= CW'(pad_q)) && (col_q < CW'(WIDTH) + CW'(pad_q));
    assign last_beat = (row_q == row_lim - 1'b1) && (col_q == col_lim - 1'b1);
    assign ld        = (state_q == S_RUN) && (!out_valid_q || out_m.ready);

    // NOTE: every variable written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pad_d       = pad_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        advance     = 1'b0;

        // An accepted beat empties the register unless a new one is loaded below.
        if (out_valid_q && out_m.ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // done_q is high only on the first idle cycle; a start there is dropped.
                if (start && !done_q) begin
                    pad_d   = (cfg_pad > PW'(MAX_PAD)) ? PW'(MAX_PAD) : cfg_pad;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ld) begin
                    if (interior) begin
                        in_ready = 1'b1;
                        if (in_s.valid) begin
                            out_data_d = in_s.data;
                            advance    = 1'b1;
                        end
                    end else begin
                        out_data_d = '0;
                        advance    = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_m.ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            out_valid_d = 1'b1;
            if (last_beat) begin
                out_last_d = 1'b1;
                row_d      = '0;
                col_d      = '0;
                state_d    = S_DRAIN;
            end else if (col_q == col_lim - 1'b1) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the output data
    // register is reset too because its reset value is observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pad_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pad_q       <= pad_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign in_s.ready  = in_ready;
    assign out_m.valid = out_valid_q;
    assign out_m.data  = out_data_q;
    assign out_m.last  = out_last_q;
endmodule

// File: tb/tb_zero_pad_stream.sv
// Directed bench for zero_pad_stream on a 3x2 map with 4 lanes: border zeros,
// stalls on both sides, pad clamping, mid-frame reset and ignored starts.
module tb_zero_pad_stream;
    localparam int DWID = 32;
    localparam int CH   = 4;
    localparam int DW   = DWID * CH;
    localparam int W    = 3;
    localparam int H    = 2;

    // Pixel index per output beat for p=1 (0 = zero border beat).
    localparam int EXP_P1 [20] = '{0, 0, 0, 0, 0,
                                  0, 1, 2, 3, 0,
                                  0, 4, 5, 6, 0,
                                  0, 0, 0, 0, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] cfg_pad;
    logic       busy;
    logic       done;

    zero_pad_stream_if #(.DW(DW)) in_if ();
    zero_pad_stream_if #(.DW(DW)) out_if ();

    zero_pad_stream #(
        .DATA_WIDTH (DWID),
        .CHANNELS   (CH),
        .WIDTH      (W),
        .HEIGHT     (H),
        .MAX_PAD    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cfg_pad (cfg_pad),
        .busy    (busy),
        .done    (done),
        .in_s    (in_if.slave),
        .out_m   (out_if.master)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    int            in_idx;
    int            stall_cnt;
    int            last_acc_cyc;
    bit            prev_stall;
    logic [DW-1:0] prev_data;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int k);
        logic [DW-1:0] r;
        for (int c = 0; c < CH; c++)
            r[c*DWID +: DWID] = 32'hA000_0000 + 32'(c << 24) + 32'(k);
        return r;
    endfunction

    function automatic logic [DW-1:0] beat_val(input int k);
        return (k == 0) ? '0 : pix(k);
    endfunction

    // Pixel index expected at output position i of a frame padded by p.
    function automatic int exp_idx(input int p, input int i);
        int cw, r, c;
        cw = W + 2 * p;
        r  = i / cw;
        c  = i % cw;
        if (r >= p && r < H + p && c >= p && c < W + p) return (r - p) * W + (c - p) + 1;
        return 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},      DW'(busy),         '0);
        check({tag, " out_valid"}, DW'(out_if.valid), '0);
        check({tag, " out_data"},  out_if.data,       '0);
        check({tag, " out_last"},  DW'(out_if.last),  '0);
        check({tag, " done"},      DW'(done),         '0);
        check({tag, " in_ready"},  DW'(in_if.ready),  '0);
    endtask

    // Drives one frame and records accepted output beats. Inputs change 1ns after
    // the rising edge; handshakes and outputs are sampled on the falling edge.
    task automatic run_frame(input logic [1:0] pad, input bit toggle_rdy, input int stall_pix,
                             input int stall_len, input int rst_after, input bit busy_start,
                             input bit done_start);
        bit finished = 1'b0;
        got_data.delete();
        got_last.delete();
        in_idx       = 1;
        stall_cnt    = 0;
        last_acc_cyc = -10;
        prev_stall   = 1'b0;
        @(posedge clk); #1;
        start   = 1'b1;
        cfg_pad = pad;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after start", DW'(busy), DW'(1));
        for (int cyc = 0; cyc < 500 && !finished; cyc++) begin
            out_if.ready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
            in_if.valid  = !(in_idx == stall_pix && stall_cnt < stall_len);
            in_if.data   = in_if.valid ? pix(in_idx) : {CH{32'hDEAD_BEEF}};
            start        = busy_start && (cyc == 3);
            cfg_pad      = (busy_start && cyc == 3) ? 2'd0 : pad;
            @(negedge clk);
            if (prev_stall) begin
                check($sformatf("stall valid cyc%0d", cyc), DW'(out_if.valid), DW'(1));
                check($sformatf("stall data cyc%0d", cyc), out_if.data, prev_data);
            end
            if (in_if.valid && in_if.ready) in_idx++;
            else if (!in_if.valid && in_if.ready) stall_cnt++;
            if (out_if.valid && out_if.ready) begin
                got_data.push_back(out_if.data);
                got_last.push_back(out_if.last);
                if (out_if.last) last_acc_cyc = cyc;
            end
            prev_stall = out_if.valid && !out_if.ready;
            prev_data  = out_if.data;
            if (done) begin
                check("done cycle after last", DW'(cyc), DW'(last_acc_cyc + 1));
                finished = 1'b1;
                if (done_start) begin
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                    check("start with done ignored", DW'(busy), '0);
                end
            end else if (rst_after > 0 && got_data.size() == rst_after) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("mid-frame reset");
                finished = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        if (!finished) check("frame timeout", '0, DW'(1));
    endtask

    task automatic compare_frame(input string tname, input int p, input bit lanes);
        int n, idx;
        n = (H + 2 * p) * (W + 2 * p);
        check({tname, " beat count"}, DW'(got_data.size()), DW'(n));
        check({tname, " inputs consumed"}, DW'(in_idx - 1), DW'(H * W));
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            idx = (p == 1) ? EXP_P1[i] : exp_idx(p, i);
            if (lanes) begin
                for (int c = 0; c < CH; c++)
                    check($sformatf("%s beat%0d lane%0d", tname, i, c),
                          DW'(got_data[i][c*DWID +: DWID]), DW'(beat_val(idx)[c*DWID +: DWID]));
            end else begin
                check($sformatf("%s beat%0d data", tname, i), got_data[i], beat_val(idx));
            end
            check($sformatf("%s beat%0d last", tname, i), DW'(got_last[i]), DW'(i == n - 1));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        cfg_pad      = 2'd0;
        in_if.valid  = 1'b1;
        in_if.data   = pix(1);
        in_if.last   = 1'b0;
        out_if.ready = 1'b1;
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: p=1, downstream always ready.
        run_frame(2'd1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        compare_frame("t1", 1, 1'b0);

        // 2: downstream ready alternates.
        run_frame(2'd1, 1'b1, 0, 0, 0, 1'b0, 1'b0);
        compare_frame("t2", 1, 1'b0);

        // 3: input stalls three cycles at pixel 4.
        run_frame(2'd1, 1'b0, 4, 3, 0, 1'b0, 1'b0);
        compare_frame("t3", 1, 1'b0);

        // 4: pass-through, then an out-of-range pad clamped to 2.
        run_frame(2'd0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        compare_frame("t4 p0", 0, 1'b0);
        run_frame(2'd3, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        compare_frame("t4 p3", 2, 1'b0);

        // 5: reset after seven beats, then a clean frame.
        run_frame(2'd1, 1'b0, 0, 0, 7, 1'b0, 1'b0);
        @(negedge clk);
        check_reset_outputs("reset held");
        rst_n = 1'b1;
        run_frame(2'd1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        compare_frame("t5", 1, 1'b0);

        // 6: start pulsed mid-frame and on the done cycle; lanes checked one by one.
        run_frame(2'd1, 1'b1, 0, 0, 0, 1'b1, 1'b1);
        compare_frame("t6", 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
